// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and IDLE/FETCH/HALT control.
// Define FETCH_BOUNDS_CHECK_EN to halt with a sticky fault on fetches at or beyond MEM_DEPTH.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter int unsigned MEM_DEPTH = 50
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [31:0] pc_out,
  input  logic [31:0] imem_instruction,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instruction,
  output logic [31:0] id_pc,
  output logic        fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instruction_q, id_instruction_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic        fault_q, fault_d;
  logic        stalled;
  logic        out_of_range;

`ifdef FETCH_BOUNDS_CHECK_EN
  localparam logic [31:0] MEM_LIMIT = 32'(MEM_DEPTH);
  assign out_of_range = (pc_q >= MEM_LIMIT);
  assign fault        = fault_q;
`else
  logic unused_cfg;
  assign out_of_range = 1'b0;
  assign fault        = 1'b0;
  assign unused_cfg   = fault_q ^ (MEM_DEPTH == 0);
`endif

  assign stalled = id_valid_q && !id_ready;

  // Redirect outranks stall, stall outranks fetch; an out-of-range fetch halts instead of capturing.
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    id_valid_d       = id_valid_q;
    id_instruction_d = id_instruction_q;
    id_pc_d          = id_pc_q;
    fault_d          = fault_q;
    case (state_q)
      IDLE: begin
        state_d    = FETCH;
        id_valid_d = 1'b0;
      end
      FETCH: begin
        if (redirect_valid) begin
          pc_d       = redirect_target;
          id_valid_d = 1'b0;
        end else if (!stalled) begin
          if (out_of_range) begin
            fault_d    = 1'b1;
            id_valid_d = 1'b0;
            state_d    = HALT;
          end else begin
            id_instruction_d = imem_instruction;
            id_pc_d          = pc_q;
            id_valid_d       = 1'b1;
            pc_d             = pc_q + 32'd1;
          end
        end
      end
      HALT: begin
        id_valid_d = 1'b0;
      end
      default: begin
        state_d    = IDLE;
        id_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      pc_q             <= RESET_PC;
      id_valid_q       <= 1'b0;
      id_instruction_q <= 32'd0;
      id_pc_q          <= 32'd0;
      fault_q          <= 1'b0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      id_valid_q       <= id_valid_d;
      id_instruction_q <= id_instruction_d;
      id_pc_q          <= id_pc_d;
      fault_q          <= fault_d;
    end
  end

  assign pc_out         = pc_q;
  assign id_valid       = id_valid_q;
  assign id_instruction = id_instruction_q;
  assign id_pc          = id_pc_q;

endmodule
